// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
//
// Load/store sequencer between the MEM pipeline stage and a word-only data
// memory port. One request is accepted at a time (only from IDLE) and its
// address, funct3 and store data are registered. Sub-word stores become a
// read-modify-write of the containing word. Sub-word loads are extracted and
// sign/zero extended. Misaligned or illegal requests complete with ERR=1 and
// never touch memory.
//
// Ports
//   CLK, RESET           clock; synchronous active-high reset
//   REQ_READ, REQ_WRITE  load / store request (sampled in IDLE only)
//   FUNCT3, ADDR, WDATA  RV32 funct3, byte address, store data
//   RDATA                extended load result (registered, valid with DONE)
//   BUSY                 high while a memory phase is in progress
//   DONE                 one-cycle completion pulse
//   ERR                  illegal/misaligned flag, valid with DONE
//   MEM_READ, MEM_WRITE  2'b11 = word read / word write, else 2'b00
//   MEM_ADDR             word-aligned address of the latched request
//   MEM_WDATA            word to write
//   MEM_RDATA            combinational read data from memory
// -----------------------------------------------------------------------------
module dmem_access_ctrl (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ_READ,
  input  logic        REQ_WRITE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic [31:0] RDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [1:0]  MEM_READ,
  output logic [1:0]  MEM_WRITE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  input  logic [31:0] MEM_RDATA
);

  // RV32 load/store funct3 encodings (stores use only B, H, W).
  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD,
    S_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;          // latched byte address
  logic [2:0]  f_q, f_d;          // latched funct3
  logic [31:0] d_q, d_d;          // latched store data
  logic [31:0] merge_q, merge_d;  // merged word for sub-word stores
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        legal;

  // ---------------------------------------------------------------------------
  // Load extraction: pick the lane addressed by the low address bits and
  // extend it according to funct3.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  f);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f)
      F_B:     r = {{24{b[7]}}, b};
      F_BU:    r = {24'h0, b};
      F_H:     r = {{16{h[15]}}, h};
      F_HU:    r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Store merge: overwrite only the addressed byte/half of the read word.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] data,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f);
    logic [31:0] r;
    r = word;
    if (f == F_B) begin
      case (lane)
        2'd0:    r[7:0]   = data[7:0];
        2'd1:    r[15:8]  = data[7:0];
        2'd2:    r[23:16] = data[7:0];
        default: r[31:24] = data[7:0];
      endcase
    end else if (lane[1]) begin
      r[31:16] = data[15:0];
    end else begin
      r[15:0] = data[15:0];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Legality of the request currently presented on the inputs. Both request
  // lines high is illegal, as is any funct3 outside the load/store sets or an
  // access that is not naturally aligned.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    legal = 1'b0;
    if (REQ_READ ^ REQ_WRITE) begin
      case (FUNCT3)
        F_B:     legal = 1'b1;
        F_H:     legal = ~ADDR[0];
        F_W:     legal = (ADDR[1:0] == 2'b00);
        F_BU:    legal = REQ_READ;
        F_HU:    legal = REQ_READ & ~ADDR[0];
        default: legal = 1'b0;
      endcase
    end
  end

  assign accept = (state_q == S_IDLE) && (REQ_READ || REQ_WRITE);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (REQ_READ || REQ_WRITE) begin
          if (!legal)              state_d = S_RESP;
          else if (REQ_READ)       state_d = S_LD;
          else if (FUNCT3 == F_W)  state_d = S_WR;
          else                     state_d = S_RMW_RD;
        end
      end
      S_LD:     state_d = S_RESP;
      S_WR:     state_d = S_RESP;
      S_RMW_RD: state_d = S_RMW_WR;
      S_RMW_WR: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    a_d     = a_q;
    f_d     = f_q;
    d_d     = d_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    if (accept) begin
      a_d   = ADDR;
      f_d   = FUNCT3;
      d_d   = WDATA;
      err_d = ~legal;
      // A rejected request reports a zero result; legal stores keep RDATA.
      if (!legal) rdata_d = 32'h0;
    end

    if (state_q == S_LD)
      rdata_d = load_extract(MEM_RDATA, a_q[1:0], f_q);

    if (state_q == S_RMW_RD)
      merge_d = store_merge(MEM_RDATA, d_q, a_q[1:0], f_q);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      a_q     <= 32'h0;
      f_q     <= 3'h0;
      d_q     <= 32'h0;
      merge_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      f_q     <= f_d;
      d_q     <= d_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    BUSY      = 1'b0;
    DONE      = 1'b0;
    MEM_READ  = 2'b00;
    MEM_WRITE = 2'b00;
    MEM_WDATA = 32'h0;
    case (state_q)
      S_LD: begin
        BUSY     = 1'b1;
        MEM_READ = 2'b11;
      end
      S_RMW_RD: begin
        BUSY     = 1'b1;
        MEM_READ = 2'b11;
      end
      S_WR: begin
        BUSY      = 1'b1;
        // Gating by RESET keeps an aborted store from landing in memory.
        MEM_WRITE = RESET ? 2'b00 : 2'b11;
        MEM_WDATA = d_q;
      end
      S_RMW_WR: begin
        BUSY      = 1'b1;
        MEM_WRITE = RESET ? 2'b00 : 2'b11;
        MEM_WDATA = merge_q;
      end
      S_RESP:  DONE = 1'b1;
      default: ;
    endcase
  end

  assign MEM_ADDR = {a_q[31:2], 2'b00};
  assign RDATA    = rdata_q;
  assign ERR      = err_q;

endmodule
